// File: rtl/driver_seq_pkg.sv
// Shared register map, CONTROL/STATUS bit positions and program-state encoding
// for the driver sequencing control block.
package driver_seq_pkg;

  localparam int unsigned REG_ADDR_PUSH = 32'h000;
  localparam int unsigned REG_CONTROL   = 32'h004;
  localparam int unsigned REG_STATUS    = 32'h008;
  localparam int unsigned REG_DROP_CNT  = 32'h00C;
  localparam int unsigned REG_MON_BASE  = 32'h100;

  localparam int CTRL_RUN_BIT         = 0;
  localparam int CTRL_END_BIT         = 1;
  localparam int CTRL_ABORT_BIT       = 2;
  localparam int CTRL_FREEZE_ADDR_BIT = 3;
  localparam int CTRL_FREEZE_VEC_BIT  = 4;
  localparam int CTRL_SEND_CONSEC_BIT = 7;
  localparam int CTRL_CONSEC_LSB      = 8;

  localparam int STAT_ACTIVE_BIT   = 0;
  localparam int STAT_BUSY_BIT     = 1;
  localparam int STAT_FULL_BIT     = 2;
  localparam int STAT_OVERFLOW_BIT = 3;
  localparam int STAT_STATE_LSB    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ENDING = 2'd2
  } prog_state_t;

endpackage

// File: rtl/driver_burst_gen.sv
// Consecutive-address generator: after start it owes `count` pushes of
// base + k*STRIDE, one per non-stalled cycle, until done or cancelled.
module driver_burst_gen #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] base,
  input  logic [CNT_W-1:0]  count,
  input  logic              stall,
  input  logic              cancel,
  output logic              busy,
  output logic              emit,
  output logic [DATA_W-1:0] addr
);

  logic [DATA_W-1:0] cur;
  logic [CNT_W-1:0]  rem;

  assign busy = (rem != '0);
  assign emit = busy && !stall && !cancel;
  // Address arithmetic wraps naturally at DATA_W bits.
  assign addr = cur + DATA_W'(STRIDE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= '0;
      rem <= '0;
    end else if (cancel) begin
      rem <= '0;
    end else if (start) begin
      cur <= base;
      rem <= count;
    end else if (emit) begin
      cur <= addr;
      rem <= rem - CNT_W'(1);
    end
  end

endmodule

// File: rtl/driver_seq_cntrl.sv
// Slave register block feeding the driver's address FIFO: single and burst
// pushes with drop accounting, program-state FSM, status and monitor readback.
module driver_seq_cntrl
  import driver_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_MON     = 16,
  parameter int MON_W       = 16,
  parameter int CONSEC_W    = 8,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        slave_addr,
  input  logic                     slave_rd,
  input  logic                     slave_wr,
  input  logic [DATA_W-1:0]        slave_data_in,
  output logic [DATA_W-1:0]        slave_data_out,
  output logic                     slave_rd_valid,
  input  logic [NUM_MON*MON_W-1:0] addr_mon_cnts,
  input  logic                     addr_fifo_full,
  output logic [DATA_W-1:0]        addr_fifo_din,
  output logic                     addr_fifo_wr,
  output logic                     active_program,
  output logic                     end_program,
  output logic                     freeze_addr_fifo,
  output logic                     freeze_vector_fifo
);

  logic                sel_push, sel_ctrl, sel_drop;
  logic                run_p, end_p, abort_p;
  logic                push_ok, push_drop;
  logic                send_consec;
  logic [CONSEC_W-1:0] consec_count;
  logic [DATA_W-1:0]   last_base;
  logic [DATA_W-1:0]   drop_cnt;
  logic                overflow;
  logic                burst_busy, burst_emit;
  logic [DATA_W-1:0]   burst_addr;
  logic [DATA_W-1:0]   rdata;
  prog_state_t         state_q, state_d;

  assign sel_push = slave_wr && (slave_addr == ADDR_W'(REG_ADDR_PUSH));
  assign sel_ctrl = slave_wr && (slave_addr == ADDR_W'(REG_CONTROL));
  assign sel_drop = slave_wr && (slave_addr == ADDR_W'(REG_DROP_CNT));

  assign run_p   = sel_ctrl && slave_data_in[CTRL_RUN_BIT];
  assign end_p   = sel_ctrl && slave_data_in[CTRL_END_BIT];
  assign abort_p = sel_ctrl && slave_data_in[CTRL_ABORT_BIT];

  // Host pushes are refused while a burst is still owed, not merely stalled.
  assign push_ok   = sel_push && !burst_busy && !addr_fifo_full && !freeze_addr_fifo;
  assign push_drop = sel_push && !push_ok;

  driver_burst_gen #(
    .DATA_W (DATA_W),
    .CNT_W  (CONSEC_W),
    .STRIDE (ADDR_STRIDE)
  ) u_burst (
    .clk    (clk),
    .reset  (reset),
    .start  (push_ok && send_consec),
    .base   (slave_data_in),
    .count  (consec_count),
    .stall  (addr_fifo_full || freeze_addr_fifo),
    .cancel (abort_p),
    .busy   (burst_busy),
    .emit   (burst_emit),
    .addr   (burst_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_fifo_wr       <= 1'b0;
      addr_fifo_din      <= '0;
      last_base          <= '0;
      drop_cnt           <= '0;
      overflow           <= 1'b0;
      freeze_addr_fifo   <= 1'b0;
      freeze_vector_fifo <= 1'b0;
      send_consec        <= 1'b0;
      consec_count       <= '0;
      slave_rd_valid     <= 1'b0;
      slave_data_out     <= '0;
    end else begin
      addr_fifo_wr   <= push_ok || burst_emit;
      slave_rd_valid <= slave_rd;
      slave_data_out <= slave_rd ? rdata : '0;
      if (push_ok) begin
        addr_fifo_din <= slave_data_in;
        last_base     <= slave_data_in;
      end else if (burst_emit) begin
        addr_fifo_din <= burst_addr;
      end
      if (sel_drop) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else if (push_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DATA_W'(1);
      end
      if (sel_ctrl) begin
        freeze_addr_fifo   <= slave_data_in[CTRL_FREEZE_ADDR_BIT];
        freeze_vector_fifo <= slave_data_in[CTRL_FREEZE_VEC_BIT];
        send_consec        <= slave_data_in[CTRL_SEND_CONSEC_BIT];
        consec_count       <= slave_data_in[CTRL_CONSEC_LSB +: CONSEC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    active_program = 1'b0;
    end_program    = 1'b0;
    unique case (state_q)
      IDLE:   if (run_p) state_d = ACTIVE;
      ACTIVE: begin
        active_program = 1'b1;
        if (end_p) state_d = ENDING;
      end
      ENDING: begin
        end_program = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_p) state_d = IDLE;
  end

  // Read mux sees pre-edge register values, so a same-cycle write is not visible.
  always_comb begin
    rdata = '0;
    if (slave_addr == ADDR_W'(REG_ADDR_PUSH)) begin
      rdata = last_base;
    end else if (slave_addr == ADDR_W'(REG_CONTROL)) begin
      rdata[CTRL_FREEZE_ADDR_BIT]                = freeze_addr_fifo;
      rdata[CTRL_FREEZE_VEC_BIT]                 = freeze_vector_fifo;
      rdata[CTRL_SEND_CONSEC_BIT]                = send_consec;
      rdata[CTRL_CONSEC_LSB +: CONSEC_W]         = consec_count;
    end else if (slave_addr == ADDR_W'(REG_STATUS)) begin
      rdata[STAT_ACTIVE_BIT]     = active_program;
      rdata[STAT_BUSY_BIT]       = burst_busy;
      rdata[STAT_FULL_BIT]       = addr_fifo_full;
      rdata[STAT_OVERFLOW_BIT]   = overflow;
      rdata[STAT_STATE_LSB +: 2] = state_q;
    end else if (slave_addr == ADDR_W'(REG_DROP_CNT)) begin
      rdata = drop_cnt;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        if (slave_addr == ADDR_W'(REG_MON_BASE + 32'(4 * i))) begin
          rdata[MON_W-1:0] = addr_mon_cnts[i*MON_W +: MON_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_driver_seq_cntrl.sv
// Bench for driver_seq_cntrl: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a queue-based behavioural model.
module tb_driver_seq_cntrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int NUM_MON = 16;
  localparam int MON_W   = 16;
  localparam int CONSEC  = 8;
  localparam int STRIDE  = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [ADDR_W-1:0]        slave_addr = '0;
  logic                     slave_rd = 1'b0;
  logic                     slave_wr = 1'b0;
  logic [DATA_W-1:0]        slave_data_in = '0;
  logic [DATA_W-1:0]        slave_data_out;
  logic                     slave_rd_valid;
  logic [NUM_MON*MON_W-1:0] addr_mon_cnts = '0;
  logic                     addr_fifo_full = 1'b0;
  logic [DATA_W-1:0]        addr_fifo_din;
  logic                     addr_fifo_wr;
  logic                     active_program;
  logic                     end_program;
  logic                     freeze_addr_fifo;
  logic                     freeze_vector_fifo;

  always #5 clk = ~clk;

  driver_seq_cntrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_MON(NUM_MON), .MON_W(MON_W),
    .CONSEC_W(CONSEC), .ADDR_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .reset(reset), .slave_addr(slave_addr), .slave_rd(slave_rd),
    .slave_wr(slave_wr), .slave_data_in(slave_data_in), .slave_data_out(slave_data_out),
    .slave_rd_valid(slave_rd_valid), .addr_mon_cnts(addr_mon_cnts),
    .addr_fifo_full(addr_fifo_full), .addr_fifo_din(addr_fifo_din),
    .addr_fifo_wr(addr_fifo_wr), .active_program(active_program),
    .end_program(end_program), .freeze_addr_fifo(freeze_addr_fifo),
    .freeze_vector_fifo(freeze_vector_fifo)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural model: exp_q holds the burst addresses still owed to the FIFO.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_last, m_drop, m_din, m_rdata;
  bit                m_ovf, m_fa, m_fv, m_send, m_wr, m_rv;
  int                m_count, m_state;

  logic [DATA_W-1:0] got_addr[$];
  int                got_cyc[$];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] idx;
    model_read = '0;
    if (a == 32'h0)       model_read = m_last;
    else if (a == 32'h4)  model_read = {16'b0, 8'(m_count), m_send, 2'b0, m_fv, m_fa, 3'b0};
    else if (a == 32'h8)  model_read = {26'b0, 2'(m_state), m_ovf, addr_fifo_full,
                                        exp_q.size() != 0, m_state == 1};
    else if (a == 32'hC)  model_read = m_drop;
    else if (a >= 32'h100 && a < 32'h100 + 4 * NUM_MON && a[1:0] == 2'b00) begin
      idx = (a - 32'h100) >> 2;
      model_read = {16'b0, addr_mon_cnts[idx*MON_W +: MON_W]};
    end
  endfunction

  always @(posedge clk) begin : model
    bit busy_pre, stall, wr_ctrl;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      m_last = '0; m_drop = '0; m_ovf = 0; m_fa = 0; m_fv = 0; m_send = 0;
      m_count = 0; m_state = 0; m_wr = 0; m_rv = 0; m_rdata = '0;
    end else begin
      busy_pre = exp_q.size() != 0;
      stall    = addr_fifo_full || m_fa;
      wr_ctrl  = slave_wr && slave_addr == 32'h4;
      m_rv     = slave_rd;
      m_rdata  = slave_rd ? model_read(slave_addr) : '0;
      m_wr     = 0;
      if (wr_ctrl && slave_data_in[2]) exp_q.delete();
      else if (busy_pre && !stall) begin
        m_wr  = 1;
        m_din = exp_q.pop_front();
      end
      if (slave_wr && slave_addr == 32'h0) begin
        if (!busy_pre && !addr_fifo_full && !m_fa) begin
          m_wr   = 1;
          m_din  = slave_data_in;
          m_last = slave_data_in;
          if (m_send)
            for (int k = 1; k <= m_count; k++) exp_q.push_back(slave_data_in + DATA_W'(k * STRIDE));
        end else begin
          if (m_drop != '1) m_drop = m_drop + 1;
          m_ovf = 1;
        end
      end
      if (slave_wr && slave_addr == 32'hC) begin
        m_drop = '0;
        m_ovf  = 0;
      end
      if (wr_ctrl && slave_data_in[2])                       m_state = 0;
      else if (m_state == 2)                                 m_state = 0;
      else if (wr_ctrl && slave_data_in[1] && m_state == 1)  m_state = 2;
      else if (wr_ctrl && slave_data_in[0] && m_state == 0)  m_state = 1;
      if (wr_ctrl) begin
        m_fa    = slave_data_in[3];
        m_fv    = slave_data_in[4];
        m_send  = slave_data_in[7];
        m_count = int'(slave_data_in[15:8]);
      end
    end
  end

  always @(posedge clk) begin : compare
    #2;
    if (addr_fifo_wr === 1'b1) begin
      got_addr.push_back(addr_fifo_din);
      got_cyc.push_back(cyc);
    end
    check("fifo_wr", addr_fifo_wr, m_wr);
    if (m_wr) check("fifo_din", addr_fifo_din, m_din);
    check("active_program", active_program, m_state == 1);
    check("end_program", end_program, m_state == 2);
    check("freeze_addr", freeze_addr_fifo, m_fa);
    check("freeze_vec", freeze_vector_fifo, m_fv);
    check("rd_valid", slave_rd_valid, m_rv);
    if (m_rv) check("rd_data", slave_data_out, m_rdata);
  end

  task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_rd      = rd;
    slave_wr      = wr;
    slave_addr    = a;
    slave_data_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus(1'b1, 1'b0, a, 32'h0);
    idle(1);
    check({name, "_valid"}, slave_rd_valid, 1'b1);
    check(name, slave_data_out, exp);
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_cyc.delete();
  endtask

  logic [31:0] r_addr, r_data;
  int          sel;

  initial begin
    idle(3);
    reset = 1'b1;
    idle(1);
    rd_chk("reset_status", 32'h8, 32'h0);

    // single push and readback of the last accepted base
    clear_got();
    bus(1'b0, 1'b1, 32'h0, 32'h1234);
    idle(3);
    check("single_count", got_addr.size(), 1);
    check("single_data", got_addr[0], 32'h1234);
    rd_chk("last_base", 32'h0, 32'h1234);

    // burst of 3 after base 0x100, STATUS busy while it runs
    bus(1'b0, 1'b1, 32'h4, 32'h0000_0380);
    clear_got();
    bus(1'b0, 1'b1, 32'h0, 32'h100);
    bus(1'b1, 1'b0, 32'h8, 32'h0);
    idle(1);
    check("burst_status", slave_data_out, 32'h2);
    idle(6);
    check("burst_count", got_addr.size(), 4);
    for (int k = 0; k < 4; k++) check("burst_addr", got_addr[k], 32'h100 + 32'(4 * k));
    for (int k = 1; k < 4; k++) check("burst_gap", got_cyc[k] - got_cyc[k-1], 1);

    // same burst with a two-cycle full stall after the second push
    clear_got();
    bus(1'b0, 1'b1, 32'h0, 32'h100);
    idle(2);
    addr_fifo_full = 1'b1;
    idle(2);
    addr_fifo_full = 1'b0;
    idle(6);
    check("stall_count", got_addr.size(), 4);
    for (int k = 0; k < 4; k++) check("stall_addr", got_addr[k], 32'h100 + 32'(4 * k));
    check("stall_gap1", got_cyc[1] - got_cyc[0], 1);
    check("stall_gap2", got_cyc[2] - got_cyc[1], 3);
    check("stall_gap3", got_cyc[3] - got_cyc[2], 1);
    rd_chk("stall_drop", 32'hC, 32'h0);

    // drops: full push, then a push during a burst; DROP_CNT write clears
    addr_fifo_full = 1'b1;
    bus(1'b0, 1'b1, 32'h0, 32'hAAA);
    idle(1);
    addr_fifo_full = 1'b0;
    bus(1'b0, 1'b1, 32'h0, 32'h200);
    bus(1'b0, 1'b1, 32'h0, 32'h300);
    idle(6);
    rd_chk("drop_cnt2", 32'hC, 32'h2);
    rd_chk("drop_status", 32'h8, 32'h8);
    bus(1'b0, 1'b1, 32'hC, 32'h5A5A);
    rd_chk("drop_cleared", 32'hC, 32'h0);
    rd_chk("ovf_cleared", 32'h8, 32'h0);

    // program run / end / abort
    bus(1'b0, 1'b1, 32'h4, 32'h1);
    idle(1);
    check("run_active", active_program, 1'b1);
    rd_chk("run_status", 32'h8, 32'h11);
    bus(1'b0, 1'b1, 32'h4, 32'h2);
    idle(1);
    check("end_pulse", end_program, 1'b1);
    check("end_active_low", active_program, 1'b0);
    idle(1);
    check("end_pulse_gone", end_program, 1'b0);
    bus(1'b0, 1'b1, 32'h4, 32'h1);
    idle(1);
    check("rerun_active", active_program, 1'b1);
    bus(1'b0, 1'b1, 32'h4, 32'h7);
    idle(1);
    check("abort_active", active_program, 1'b0);
    check("abort_no_end", end_program, 1'b0);
    idle(1);
    check("abort_no_end2", end_program, 1'b0);

    // monitor readback and out-of-range address
    for (int i = 0; i < NUM_MON; i++) addr_mon_cnts[i*MON_W +: MON_W] = 16'($urandom);
    addr_mon_cnts[5*MON_W +: MON_W] = 16'hBEEF;
    rd_chk("mon5", 32'h114, 32'h0000_BEEF);
    rd_chk("mon_oob", 32'h100 + 32'(4 * NUM_MON), 32'h0);

    // reset asserted mid-burst stops all further pushes
    bus(1'b0, 1'b1, 32'h4, 32'h0000_0380);
    clear_got();
    bus(1'b0, 1'b1, 32'h0, 32'h500);
    idle(1);
    reset = 1'b0;
    idle(3);
    check("rst_mid_count", got_addr.size(), 1);
    reset = 1'b1;
    idle(2);
    check("rst_after_count", got_addr.size(), 1);
    rd_chk("rst_ctrl", 32'h4, 32'h0);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 2500; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: r_addr = 32'h0;
        3:       r_addr = 32'h4;
        4:       r_addr = 32'h8;
        5:       r_addr = 32'hC;
        6, 7:    r_addr = 32'h100 + 32'(4 * $urandom_range(0, NUM_MON + 1));
        default: r_addr = 32'($urandom_range(0, 127));
      endcase
      r_data = $urandom;
      if (r_addr == 32'h4) begin
        r_data    = r_data & 32'h0000_0783;
        r_data[2] = ($urandom_range(0, 3) == 0);
        r_data[3] = ($urandom_range(0, 7) == 0);
        r_data[4] = ($urandom_range(0, 3) == 0);
      end
      if (i % 200 == 0)
        for (int m = 0; m < NUM_MON; m++) addr_mon_cnts[m*MON_W +: MON_W] = 16'($urandom);
      bus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), r_addr, r_data);
      addr_fifo_full = ($urandom_range(0, 3) == 0);
      if (i == 1200) reset = 1'b0;
      if (i == 1203) reset = 1'b1;
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/driver_seq_cntrl.md
Name: driver_seq_cntrl

Overview:
Parametrised successor to the driver control register block. It exposes a slave register interface for address-FIFO pushes, program control, status and N address-monitor counters. It adds a consecutive-address burst generator, FIFO-full back-pressure with drop accounting, and a program-state FSM. It sits between the host slave bus and the driver's address FIFO and vector engine.

Parameters:
DATA_W, 32, slave data, address-FIFO data and register width
ADDR_W, 32, slave address width (byte addressing)
NUM_MON, 16, number of address-monitor counter channels (1..64)
MON_W, 16, width of each monitor counter (<= DATA_W)
CONSEC_W, 8, width of the burst-count field
ADDR_STRIDE, 4, increment between consecutive burst addresses

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
slave_addr  in  ADDR_W  register byte address
slave_rd  in  1  read strobe, one cycle per access
slave_wr  in  1  write strobe, one cycle per access
slave_data_in  in  DATA_W  write data
slave_data_out  out  DATA_W  read data, registered
slave_rd_valid  out  1  one-cycle pulse, aligned with slave_data_out
addr_mon_cnts  in  NUM_MON*MON_W  flattened monitor counts; channel i at bits [i*MON_W +: MON_W]
addr_fifo_full  in  1  downstream address FIFO full
addr_fifo_din  out  DATA_W  address-FIFO push data
addr_fifo_wr  out  1  address-FIFO push strobe
active_program  out  1  program running
end_program  out  1  one-cycle pulse on program end
freeze_addr_fifo  out  1  level, from CONTROL[3]
freeze_vector_fifo  out  1  level, from CONTROL[4]

Behaviour:
- Clock is clk. Reset is asynchronous and active-low. While reset==0, all outputs and registers are 0 and the FSM is in IDLE.
- Register map (byte offsets):
  - 0x000 ADDR_PUSH: write pushes; read returns last accepted base address.
  - 0x004 CONTROL.
  - 0x008 STATUS: read-only.
  - 0x00C DROP_CNT: any write clears it.
  - 0x100+4*i MON[i], i < NUM_MON: zero-extended to DATA_W.
  - Any other address reads 0; writes to it are ignored.
- CONTROL bits:
  - [0] run, [1] end, [2] abort: write-one pulses, self-clearing, read back 0.
  - [3] freeze_addr_fifo, [4] freeze_vector_fifo, [7] send_consec: stored.
  - [8 +: CONSEC_W] consec_count: stored.
  - All other bits read 0.
- STATUS bits: [0] active_program, [1] burst_busy, [2] addr_fifo_full, [3] overflow (sticky; cleared by a DROP_CNT write), [5:4] FSM state encoding.
- Reads: slave_data_out and slave_rd_valid are valid 1 cycle after slave_rd. If slave_rd and slave_wr hit the same register in the same cycle, the read returns the pre-write value.
- Address push (write to ADDR_PUSH, burst idle):
  - If not full and not frozen: addr_fifo_din = data, addr_fifo_wr = 1 the next cycle.
  - Otherwise the write is dropped: DROP_CNT += 1 (saturating at all-ones) and overflow = 1.
  - If send_consec = 1 and consec_count = N > 0, the burst generator then emits N further pushes: base + k*ADDR_STRIDE, k = 1..N, modulo 2^DATA_W.
  - Burst pushes occur one per cycle, and stall (no wr, no drop) while addr_fifo_full or freeze_addr_fifo is 1.
  - A write to ADDR_PUSH while burst_busy = 1 is dropped and counted.
- Program FSM states: IDLE, ACTIVE, ENDING.
  - IDLE -> ACTIVE on run; active_program = 1 the next cycle.
  - ACTIVE -> ENDING on end. In ENDING, end_program pulses for 1 cycle and active_program falls in that same cycle. ENDING -> IDLE unconditionally.
  - Any state -> IDLE on abort. active_program = 0 the next cycle, the in-flight burst is cancelled, and there is no end_program pulse.
  - Priority within one CONTROL write: abort > end > run.
  - run while ACTIVE is ignored; end while IDLE is ignored.
- Reset asserted mid-burst or mid-program immediately clears all state, with no further pushes.

Decomposition:
- Package driver_seq_pkg holds:
  - register offset constants (ADDR_PUSH, CONTROL, STATUS, DROP_CNT, MON_BASE);
  - CONTROL and STATUS bit-position constants;
  - the FSM state enum (IDLE = 0, ACTIVE = 1, ENDING = 2).
- One sub-module, driver_burst_gen, contains the base/count/stride address generator with stall, cancel and busy outputs.

Test Plan:
- Reset, then write 0x1234 to 0x000 -> addr_fifo_wr pulses once with addr_fifo_din = 0x1234; a read of 0x000 returns 0x1234 with slave_rd_valid one cycle later.
- CONTROL = 0x0000_0380 (send_consec = 1, consec_count = 3), then push 0x100 -> pushes 0x100, 0x104, 0x108, 0x10C on consecutive cycles; STATUS[1] = 1 throughout the burst.
- Same burst with addr_fifo_full held high for 2 cycles after the 2nd push -> exactly 4 pushes in order, with a 2-cycle gap; DROP_CNT stays 0.
- Push with addr_fifo_full = 1, then push during a burst -> DROP_CNT = 2 and STATUS[3] = 1; a write to 0x00C clears both.
- Write run, then end -> active_program rises, then end_program pulses one cycle as active_program falls. Write 0x7 -> abort wins: active_program = 0 and no end_program pulse.
- Drive addr_mon_cnts channel 5 = 0xBEEF and read 0x114 -> 0x0000_BEEF. Read 0x100 + 4*NUM_MON -> 0.
